ram_responder: RTL and testbench

- Byte-addressed, big-endian memory slave answering the ControlUnit's RAM_enable/RAM_OpCode request with the MFC (memory function complete) handshake.
- Sits in DataPath behind MAR (address) and MDR (write data / read-data return).
- Performs SPARC V8 load/store sizes, sign/zero extension and alignment checking.
- Models programmable wait states so the ControlUnit's MFC wait loop is exercised.

---
 rtl/ram_responder.sv | 168 ++++++++++++++++
 tb/tb_ram_responder.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/ram_responder.sv
// Byte-addressed big-endian memory slave answering RAM_enable/RAM_OpCode requests
// with a four-phase MFC handshake, SPARC V8 load/store sizes and programmable wait states.
module ram_responder #(
    parameter int ADDR_WIDTH  = 9,
    parameter int WAIT_STATES = 2
) (
    input  logic                  Clk,
    input  logic                  RESET,
    input  logic                  RAM_enable,
    input  logic [5:0]            RAM_OpCode,
    input  logic [ADDR_WIDTH-1:0] Address,
    input  logic [31:0]           DataIn,
    output logic [31:0]           DataOut,
    output logic                  MFC,
    output logic                  ERR
);

    localparam logic [5:0] OP_LD   = 6'b000000;
    localparam logic [5:0] OP_LDUB = 6'b000001;
    localparam logic [5:0] OP_LDUH = 6'b000010;
    localparam logic [5:0] OP_LDSB = 6'b001001;
    localparam logic [5:0] OP_LDSH = 6'b001010;
    localparam logic [5:0] OP_ST   = 6'b000100;
    localparam logic [5:0] OP_STB  = 6'b000101;
    localparam logic [5:0] OP_STH  = 6'b000110;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t                state;
    logic [3:0]            wait_cnt;
    logic [5:0]            op_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           data_q;

    logic [7:0] mem [0:(1 << ADDR_WIDTH) - 1];

    logic [1:0]            size;
    logic                  is_load;
    logic                  is_store;
    logic                  is_signed;
    logic                  op_ok;
    logic                  aligned;
    logic                  access_err;
    logic                  fire;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] a1;
    logic [ADDR_WIDTH-1:0] a2;
    logic [ADDR_WIDTH-1:0] a3;
    logic [7:0]            b0;
    logic [7:0]            b1;
    logic [7:0]            b2;
    logic [7:0]            b3;
    logic [31:0]           load_data;

    always_comb begin
        size      = SZ_BYTE;
        is_load   = 1'b0;
        is_store  = 1'b0;
        is_signed = 1'b0;
        op_ok     = 1'b1;
        case (op_q)
            OP_LD:   begin is_load  = 1'b1; size = SZ_WORD; end
            OP_LDUB: begin is_load  = 1'b1; size = SZ_BYTE; end
            OP_LDUH: begin is_load  = 1'b1; size = SZ_HALF; end
            OP_LDSB: begin is_load  = 1'b1; size = SZ_BYTE; is_signed = 1'b1; end
            OP_LDSH: begin is_load  = 1'b1; size = SZ_HALF; is_signed = 1'b1; end
            OP_ST:   begin is_store = 1'b1; size = SZ_WORD; end
            OP_STB:  begin is_store = 1'b1; size = SZ_BYTE; end
            OP_STH:  begin is_store = 1'b1; size = SZ_HALF; end
            default: op_ok = 1'b0;
        endcase

        case (size)
            SZ_WORD: aligned = (addr_q[1:0] == 2'b00);
            SZ_HALF: aligned = ~addr_q[0];
            default: aligned = 1'b1;
        endcase

        access_err = ~op_ok | ~aligned;
    end

    // Byte lanes in big-endian order; offsets may wrap only for rejected accesses.
    always_comb begin
        a1 = addr_q + ADDR_WIDTH'(1);
        a2 = addr_q + ADDR_WIDTH'(2);
        a3 = addr_q + ADDR_WIDTH'(3);
        b0 = mem[addr_q];
        b1 = mem[a1];
        b2 = mem[a2];
        b3 = mem[a3];
        case (size)
            SZ_WORD: load_data = {b0, b1, b2, b3};
            SZ_HALF: load_data = {{16{is_signed & b0[7]}}, b0, b1};
            default: load_data = {{24{is_signed & b0[7]}}, b0};
        endcase
    end

    assign fire   = (state == WAIT) && RAM_enable && (wait_cnt == 4'd0);
    assign mem_we = RESET && fire && is_store && !access_err;

    // The array has no reset so contents survive a mid-operation RESET.
    always_ff @(posedge Clk) begin
        if (mem_we) begin
            case (size)
                SZ_WORD: begin
                    mem[addr_q] <= data_q[31:24];
                    mem[a1]     <= data_q[23:16];
                    mem[a2]     <= data_q[15:8];
                    mem[a3]     <= data_q[7:0];
                end
                SZ_HALF: begin
                    mem[addr_q] <= data_q[15:8];
                    mem[a1]     <= data_q[7:0];
                end
                default: mem[addr_q] <= data_q[7:0];
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (!RESET) begin
            state    <= IDLE;
            wait_cnt <= 4'd0;
            MFC      <= 1'b0;
            ERR      <= 1'b0;
            DataOut  <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (RAM_enable) begin
                        op_q     <= RAM_OpCode;
                        addr_q   <= Address;
                        data_q   <= DataIn;
                        wait_cnt <= 4'(WAIT_STATES);
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (!RAM_enable) begin
                        state <= IDLE;
                    end else if (wait_cnt != 4'd0) begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end else begin
                        MFC <= 1'b1;
                        ERR <= access_err;
                        if (is_load && !access_err) begin
                            DataOut <= load_data;
                        end
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (!RAM_enable) begin
                        MFC   <= 1'b0;
                        ERR   <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_responder.sv
// Directed bench for ram_responder: two instances (2 and 0 wait states) driven through
// the MFC handshake, with expected results queued at request time and checked on MFC.
module tb_ram_responder;

    logic        clk;
    logic        rst_n;
    logic        en2;
    logic        en0;
    logic [5:0]  op;
    logic [8:0]  addr;
    logic [31:0] din;
    logic [31:0] dout2;
    logic [31:0] dout0;
    logic        mfc2;
    logic        mfc0;
    logic        err2;
    logic        err0;
    logic        sel0;
    logic        cur_mfc;
    logic        cur_err;
    logic [31:0] cur_dout;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    int          vectors;
    int          miscompares;
    logic [31:0] last2;
    logic [31:0] last0;
    logic        saw_mfc;

    ram_responder #(.ADDR_WIDTH(9), .WAIT_STATES(2)) dut2 (
        .Clk(clk), .RESET(rst_n), .RAM_enable(en2), .RAM_OpCode(op), .Address(addr),
        .DataIn(din), .DataOut(dout2), .MFC(mfc2), .ERR(err2)
    );

    ram_responder #(.ADDR_WIDTH(9), .WAIT_STATES(0)) dut0 (
        .Clk(clk), .RESET(rst_n), .RAM_enable(en0), .RAM_OpCode(op), .Address(addr),
        .DataIn(din), .DataOut(dout0), .MFC(mfc0), .ERR(err0)
    );

    assign cur_mfc  = sel0 ? mfc0  : mfc2;
    assign cur_err  = sel0 ? err0  : err2;
    assign cur_dout = sel0 ? dout0 : dout2;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b, expected %b", tag, obs, exp);
        end
    endtask

    // One full request/MFC/release cycle; inputs are scrambled right after capture.
    task automatic apply_stimulus(input string tag, input logic use0, input logic [5:0] opc,
                                  input logic [8:0] a, input logic [31:0] d,
                                  input logic e_err, input logic [31:0] e_data, input int hold);
        exp_t x;
        exp_t y;
        int   edges;
        x.data = e_data;
        x.err  = e_err;
        x.lat  = use0 ? 1 : 3;
        @(negedge clk);
        sel0 = use0;
        op   = opc;
        addr = a;
        din  = d;
        if (use0) en0 = 1'b1; else en2 = 1'b1;
        sb.push_back(x);
        @(posedge clk);
        #1;
        op   = 6'($urandom);
        addr = 9'($urandom);
        din  = $urandom;
        edges = 0;
        do begin
            @(posedge clk);
            #1;
            edges++;
        end while (!cur_mfc && edges < 40);
        y = sb.pop_front();
        check_output({tag, " latency"}, 32'(edges), 32'(y.lat));
        check_bit({tag, " mfc"}, cur_mfc, 1'b1);
        check_bit({tag, " err"}, cur_err, y.err);
        check_output({tag, " data"}, cur_dout, y.data);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check_bit({tag, " mfc held"}, cur_mfc, 1'b1);
        end
        @(negedge clk);
        if (use0) en0 = 1'b0; else en2 = 1'b0;
        @(posedge clk);
        #1;
        check_bit({tag, " mfc release"}, cur_mfc, 1'b0);
        check_bit({tag, " err release"}, cur_err, 1'b0);
        check_output({tag, " data hold"}, cur_dout, y.data);
    endtask

    task automatic do_load(input string tag, input logic use0, input logic [5:0] opc,
                           input logic [8:0] a, input logic [31:0] exp, input int hold = 0);
        apply_stimulus(tag, use0, opc, a, 32'h0, 1'b0, exp, hold);
        if (use0) last0 = exp; else last2 = exp;
    endtask

    task automatic do_store(input string tag, input logic use0, input logic [5:0] opc,
                            input logic [8:0] a, input logic [31:0] d);
        apply_stimulus(tag, use0, opc, a, d, 1'b0, use0 ? last0 : last2, 0);
    endtask

    task automatic do_err(input string tag, input logic use0, input logic [5:0] opc,
                          input logic [8:0] a, input logic [31:0] d);
        apply_stimulus(tag, use0, opc, a, d, 1'b1, use0 ? last0 : last2, 0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n = 1'b0;
        en2   = 1'b1;
        en0   = 1'b1;
        op    = 6'b000100;
        addr  = 9'h010;
        din   = 32'h0;
        sel0  = 1'b0;
        last2 = 32'h0;
        last0 = 32'h0;

        repeat (2) @(posedge clk);
        #1;
        check_bit("reset mfc2", mfc2, 1'b0);
        check_bit("reset err2", err2, 1'b0);
        check_output("reset dout2", dout2, 32'h0);
        check_bit("reset mfc0", mfc0, 1'b0);
        check_output("reset dout0", dout0, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        en2   = 1'b0;
        en0   = 1'b0;

        do_store("st 010", 1'b0, 6'b000100, 9'h010, 32'hDEADBEEF);
        check_output("mem 010..013", {dut2.mem[16], dut2.mem[17], dut2.mem[18], dut2.mem[19]},
                     32'hDEADBEEF);
        do_load("ld 010",   1'b0, 6'b000000, 9'h010, 32'hDEADBEEF);
        do_load("ldub 011", 1'b0, 6'b000001, 9'h011, 32'h000000AD);
        do_load("ldsb 011", 1'b0, 6'b001001, 9'h011, 32'hFFFFFFAD);
        do_load("lduh 012", 1'b0, 6'b000010, 9'h012, 32'h0000BEEF);
        do_load("ldsh 012", 1'b0, 6'b001010, 9'h012, 32'hFFFFBEEF);

        do_store("st 020", 1'b0, 6'b000100, 9'h020, 32'hCAFEF00D);
        do_store("st 024", 1'b0, 6'b000100, 9'h024, 32'h01020304);
        do_store("sth 020", 1'b0, 6'b000110, 9'h020, 32'hAAAA1234);
        do_store("stb 021", 1'b0, 6'b000101, 9'h021, 32'hBBBBBB99);
        do_load("ld 020 merged", 1'b0, 6'b000000, 9'h020, 32'h1299F00D);

        do_err("ld 013 misaligned", 1'b0, 6'b000000, 9'h013, 32'h0);
        do_err("st 022 misaligned", 1'b0, 6'b000100, 9'h022, 32'h55555555);
        do_load("ld 020 after bad st", 1'b0, 6'b000000, 9'h020, 32'h1299F00D);
        do_load("ld 024 after bad st", 1'b0, 6'b000000, 9'h024, 32'h01020304);
        do_err("lduh 011 misaligned", 1'b0, 6'b000010, 9'h011, 32'h0);
        do_err("op 111111", 1'b0, 6'b111111, 9'h010, 32'h0);

        do_store("st 040", 1'b0, 6'b000100, 9'h040, 32'h11223344);
        @(negedge clk);
        sel0 = 1'b0;
        op   = 6'b000100;
        addr = 9'h040;
        din  = 32'hAAAAAAAA;
        en2  = 1'b1;
        @(negedge clk);
        en2     = 1'b0;
        saw_mfc = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
            saw_mfc = saw_mfc | mfc2;
        end
        check_bit("abort no mfc", saw_mfc, 1'b0);
        do_load("ld 040 after abort", 1'b0, 6'b000000, 9'h040, 32'h11223344);

        do_load("ld 010 hold 5", 1'b0, 6'b000000, 9'h010, 32'hDEADBEEF, 5);

        do_store("st 030", 1'b0, 6'b000100, 9'h030, 32'h0BADF00D);
        @(negedge clk);
        op   = 6'b000100;
        addr = 9'h030;
        din  = 32'hFFFFFFFF;
        en2  = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_bit("mid reset mfc", mfc2, 1'b0);
        check_output("mid reset dout", dout2, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        en2   = 1'b0;
        last2 = 32'h0;
        last0 = 32'h0;
        repeat (4) @(posedge clk);
        #1;
        check_bit("post reset mfc", mfc2, 1'b0);
        do_load("ld 030 after reset", 1'b0, 6'b000000, 9'h030, 32'h0BADF00D);

        do_store("ws0 st 010", 1'b1, 6'b000100, 9'h010, 32'hDEADBEEF);
        do_load("ws0 ld 010", 1'b1, 6'b000000, 9'h010, 32'hDEADBEEF);
        do_load("ws0 ldsb 011", 1'b1, 6'b001001, 9'h011, 32'hFFFFFFAD);
        do_store("ws0 st 020", 1'b1, 6'b000100, 9'h020, 32'hCAFEF00D);
        do_store("ws0 sth 020", 1'b1, 6'b000110, 9'h020, 32'h00001234);
        do_store("ws0 stb 021", 1'b1, 6'b000101, 9'h021, 32'h00000099);
        do_load("ws0 ld 020", 1'b1, 6'b000000, 9'h020, 32'h1299F00D);
        do_err("ws0 ld 013 misaligned", 1'b1, 6'b000000, 9'h013, 32'h0);
        do_load("ws0 lduh 022", 1'b1, 6'b000010, 9'h022, 32'h0000F00D);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
